reg_port_sched: RTL and testbench



---
 rtl/reg_sched_pkg.sv | 33 +++
 rtl/reg_port_sched_if.sv | 68 ++++++
 rtl/rr_arb2.sv | 39 +++
 rtl/reg_port_sched.sv | 157 +++++++++++++++
 tb/tb_reg_port_sched.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_sched_pkg
// Description : Shared types and constants for the register-file port
//               scheduler: FSM state encoding, default bus widths, register
//               count and the write-address legality rule.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package reg_sched_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 6;
    localparam int REG_COUNT  = 32;
    localparam int STARVE_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_GAP   = 3'd2,
        S_READ  = 3'd3,
        S_RDONE = 3'd4
    } sched_state_t;

    // A write is performed only for existing registers; register 0 is
    // read-only when it models the MIPS $zero register.
    function automatic logic addr_writable(input int unsigned addr,
                                           input logic        drop_r0);
        return (addr < REG_COUNT) && !(drop_r0 && (addr == 0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_port_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_port_sched_if
// Description : Bundle of every non-clock signal of the scheduler: the two
//               writeback request channels, the operand read channel and the
//               register-file side. The master modport is the environment
//               (requesters plus the register file), the slave modport is the
//               scheduler itself.
// Ports       : wr0_*/wr1_* write requests, rd_* read request and result,
//               rf_* register-file connection.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_port_sched_if
    import reg_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              wr0_valid;
    logic [ADDR_W-1:0] wr0_addr;
    logic [DATA_W-1:0] wr0_data;
    logic              wr0_ready;

    logic              wr1_valid;
    logic [ADDR_W-1:0] wr1_addr;
    logic [DATA_W-1:0] wr1_data;
    logic              wr1_ready;

    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              rd_ready;
    logic              rd_done;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;

    logic [ADDR_W-1:0] rf_address1;
    logic [ADDR_W-1:0] rf_address2;
    logic [ADDR_W-1:0] rf_address_wr;
    logic              rf_write;
    logic [DATA_W-1:0] rf_data_wr;
    logic [DATA_W-1:0] rf_data_out1;
    logic [DATA_W-1:0] rf_data_out2;

    modport master (
        output wr0_valid, wr0_addr, wr0_data,
        input  wr0_ready,
        output wr1_valid, wr1_addr, wr1_data,
        input  wr1_ready,
        output rd_valid, rd_addr1, rd_addr2,
        input  rd_ready, rd_done, rd_data1, rd_data2,
        input  rf_address1, rf_address2, rf_address_wr, rf_write, rf_data_wr,
        output rf_data_out1, rf_data_out2
    );

    modport slave (
        input  wr0_valid, wr0_addr, wr0_data,
        output wr0_ready,
        input  wr1_valid, wr1_addr, wr1_data,
        output wr1_ready,
        input  rd_valid, rd_addr1, rd_addr2,
        output rd_ready, rd_done, rd_data1, rd_data2,
        output rf_address1, rf_address2, rf_address_wr, rf_write, rf_data_wr,
        input  rf_data_out1, rf_data_out2
    );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant. The pointer selects the preferred
//               requester when both are active and flips after every grant.
// Ports       : clk, rst_n  - clock / async active-low reset
//               en          - grants allowed this cycle
//               req0, req1  - requests
//               gnt0, gnt1  - one-hot grants (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic en,
    input  wire logic req0,
    input  wire logic req1,
    output logic      gnt0,
    output logic      gnt1
);

    // 0 -> req0 preferred, 1 -> req1 preferred
    logic r_ptr;
    logic w_pick1;

    assign w_pick1 = req1 && (!req0 || r_ptr);
    assign gnt1    = en && w_pick1;
    assign gnt0    = en && req0 && !w_pick1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (gnt0 || gnt1) begin
            r_ptr <= ~r_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : reg_port_sched
// Description : Scheduler in front of a 32x32 register file. Shares the single
//               write port between the ALU (wr0) and load (wr1) writeback
//               channels, sequences decode operand reads, keeps reads and
//               writes exclusive in time and forces a low cycle on rf_write
//               between consecutive writes.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               bus        - reg_port_sched_if.slave (requests, read result,
//                            register-file connection)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_port_sched
    import reg_sched_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = 4,
    parameter int DROP_R0    = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    reg_port_sched_if.slave  bus
);

    localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_MAX);
    localparam logic                C_DROP_R0    = (DROP_R0 != 0);

    sched_state_t        r_state;
    logic [STARVE_W-1:0] r_starve;

    logic [ADDR_W-1:0]   r_rf_address1;
    logic [ADDR_W-1:0]   r_rf_address2;
    logic [ADDR_W-1:0]   r_rf_address_wr;
    logic [DATA_W-1:0]   r_rf_data_wr;
    logic                r_rf_write;
    logic                r_rd_done;
    logic [DATA_W-1:0]   r_rd_data1;
    logic [DATA_W-1:0]   r_rd_data2;

    logic                w_decide;
    logic                w_force_rd;
    logic                w_any_wr;
    logic                w_rd_ready;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_wr_acc;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_wr_keep;

    // ------------------------------------------------------------------
    // Arbitration. Readies are held low during reset so every output is 0.
    // ------------------------------------------------------------------
    assign w_decide   = rst_n && ((r_state == S_IDLE) || (r_state == S_GAP));
    assign w_force_rd = bus.rd_valid && (r_starve == C_STARVE_MAX);
    assign w_any_wr   = bus.wr0_valid || bus.wr1_valid;
    assign w_rd_ready = w_decide && bus.rd_valid && (w_force_rd || !w_any_wr);

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_decide && !w_force_rd),
        .req0  (bus.wr0_valid),
        .req1  (bus.wr1_valid),
        .gnt0  (w_gnt0),
        .gnt1  (w_gnt1)
    );

    assign w_wr_acc  = w_gnt0 || w_gnt1;
    assign w_wr_addr = w_gnt1 ? bus.wr1_addr : bus.wr0_addr;
    assign w_wr_data = w_gnt1 ? bus.wr1_data : bus.wr0_data;
    // Discarded writes still go through WRITE/GAP; only rf_write is masked.
    assign w_wr_keep = addr_writable(32'(w_wr_addr), C_DROP_R0);

    assign bus.wr0_ready = w_gnt0;
    assign bus.wr1_ready = w_gnt1;
    assign bus.rd_ready  = w_rd_ready;

    // ------------------------------------------------------------------
    // Read starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (!bus.rd_valid || w_rd_ready) begin
            r_starve <= '0;
        end else if (r_starve != C_STARVE_MAX) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_rf_address1   <= '0;
            r_rf_address2   <= '0;
            r_rf_address_wr <= '0;
            r_rf_data_wr    <= '0;
            r_rf_write      <= 1'b0;
            r_rd_done       <= 1'b0;
            r_rd_data1      <= '0;
            r_rd_data2      <= '0;
        end else begin
            r_rd_done  <= 1'b0;
            r_rf_write <= 1'b0;
            unique case (r_state)
                S_IDLE, S_GAP: begin
                    if (w_wr_acc) begin
                        r_state         <= S_WRITE;
                        r_rf_address_wr <= w_wr_addr;
                        r_rf_data_wr    <= w_wr_data;
                        r_rf_write      <= w_wr_keep;
                    end else if (w_rd_ready) begin
                        r_state       <= S_READ;
                        r_rf_address1 <= bus.rd_addr1;
                        r_rf_address2 <= bus.rd_addr2;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    r_state <= S_GAP;
                end
                S_READ: begin
                    // Register file output reflects rf_address1/2 this cycle
                    r_rd_data1 <= bus.rf_data_out1;
                    r_rd_data2 <= bus.rf_data_out2;
                    r_rd_done  <= 1'b1;
                    r_state    <= S_RDONE;
                end
                S_RDONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rf_address1   = r_rf_address1;
    assign bus.rf_address2   = r_rf_address2;
    assign bus.rf_address_wr = r_rf_address_wr;
    assign bus.rf_data_wr    = r_rf_data_wr;
    assign bus.rf_write      = r_rf_write;
    assign bus.rd_done       = r_rd_done;
    assign bus.rd_data1      = r_rd_data1;
    assign bus.rd_data2      = r_rd_data2;

endmodule
`default_nettype wire

// File: tb/tb_reg_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_port_sched
// Description : Testbench for reg_port_sched with a behavioural register file
//               and a transaction-level shadow of the register contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_port_sched;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int STARVE = 4;
    localparam bit DROP = 1'b1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [DW-1:0] rf_mem [32] = '{default: '0};
    logic [DW-1:0] shadow [32] = '{default: '0};

    reg_port_sched_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_port_sched #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(STARVE), .DROP_R0(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural register file: synchronous write, combinational read
    always @(posedge clk)
        if (bus.rf_write && bus.rf_address_wr < 6'd32)
            rf_mem[bus.rf_address_wr[4:0]] <= bus.rf_data_wr;
    assign bus.rf_data_out1 = (bus.rf_address1 < 6'd32) ? rf_mem[bus.rf_address1[4:0]] : '0;
    assign bus.rf_data_out2 = (bus.rf_address2 < 6'd32) ? rf_mem[bus.rf_address2[4:0]] : '0;

    function automatic logic kept(input logic [AW-1:0] a);
        return (a < 6'd32) && !(DROP && a == 6'd0);
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (kept(a)) shadow[a[4:0]] = d;
    endfunction

    function automatic logic [AW-1:0] rand_waddr();
        if ($urandom_range(0, 7) == 0) return AW'($urandom_range(32, 63));
        return AW'($urandom_range(0, 31));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.wr0_valid = 0; bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_valid = 0; bus.wr1_addr = '0; bus.wr1_data = '0;
        bus.rd_valid  = 0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        bus.wr0_valid = 1; bus.wr1_valid = 1; bus.rd_valid = 1;
        #1;
        n_vec++; if ({bus.wr0_ready, bus.wr1_ready, bus.rd_ready} !== 3'b000) begin n_err++; $display("FAIL rst_ready got=%b exp=000", {bus.wr0_ready, bus.wr1_ready, bus.rd_ready}); end
        n_vec++; if ({bus.rf_write, bus.rd_done, bus.rd_data1, bus.rd_data2} !== '0) begin n_err++; $display("FAIL rst_outs got nonzero rf_write=%b rd_done=%b", bus.rf_write, bus.rd_done); end
        n_vec++; if ({bus.rf_address1, bus.rf_address2, bus.rf_address_wr, bus.rf_data_wr} !== '0) begin n_err++; $display("FAIL rst_rfaddr got nonzero exp=0"); end
        bus.wr1_valid = 0; bus.rd_valid = 0;
        bus.wr0_addr = 6'd9; bus.wr0_data = 32'hA5A5_A5A5;
        @(negedge clk) rst_n = 1;
        tick();   // wr0 accepted -> WRITE
        bus.wr0_valid = 0;
        n_vec++; if (bus.rf_write !== 1'b1) begin n_err++; $display("FAIL rst_prewrite rf_write got=%b exp=1", bus.rf_write); end
        #2 rst_n = 0;
        #1;
        n_vec++; if (bus.rf_write !== 1'b0) begin n_err++; $display("FAIL rst_async rf_write got=%b exp=0", bus.rf_write); end
        n_vec++; if ({bus.rf_address_wr, bus.rf_data_wr} !== '0) begin n_err++; $display("FAIL rst_async_wr got=%h/%h exp=0", bus.rf_address_wr, bus.rf_data_wr); end
        @(negedge clk) rst_n = 1;
        bus.wr0_valid = 1; bus.wr0_addr = 6'd3;
        bus.wr1_valid = 1; bus.wr1_addr = 6'd4;
        #1;
        n_vec++; if ({bus.wr0_ready, bus.wr1_ready} !== 2'b10) begin n_err++; $display("FAIL rst_first_rr got=%b exp=10", {bus.wr0_ready, bus.wr1_ready}); end
        clear_inputs();
    endtask

    task automatic test_contention();
        logic [1:0] g0 [6] = '{1, 0, 0, 0, 1, 0};
        logic [1:0] g1 [6] = '{0, 0, 1, 0, 0, 0};
        logic       rfw [6] = '{0, 1, 0, 1, 0, 1};
        logic [AW-1:0] wa [6] = '{0, 3, 0, 4, 0, 3};
        bus.wr0_valid = 1; bus.wr0_addr = 6'd3; bus.wr0_data = 32'h3333_0003;
        bus.wr1_valid = 1; bus.wr1_addr = 6'd4; bus.wr1_data = 32'h4444_0004;
        #1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            n_vec++; if ({bus.wr0_ready, bus.wr1_ready} !== {g0[c][0], g1[c][0]}) begin n_err++; $display("FAIL cont_grant c=%0d got=%b exp=%b", c, {bus.wr0_ready, bus.wr1_ready}, {g0[c][0], g1[c][0]}); end
            n_vec++; if (bus.rf_write !== rfw[c]) begin n_err++; $display("FAIL cont_rfw c=%0d got=%b exp=%b", c, bus.rf_write, rfw[c]); end
            if (rfw[c]) begin n_vec++; if (bus.rf_address_wr !== wa[c]) begin n_err++; $display("FAIL cont_addr c=%0d got=%0d exp=%0d", c, bus.rf_address_wr, wa[c]); end end
            if (bus.wr0_ready) model_write(bus.wr0_addr, bus.wr0_data);
            if (bus.wr1_ready) model_write(bus.wr1_addr, bus.wr1_data);
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_starvation();
        logic [DW-1:0] e1, e2;
        e1 = '0; e2 = '0;
        bus.wr0_valid = 1; bus.wr0_addr = 6'd3; bus.wr0_data = 32'h0BAD_0003;
        bus.wr1_valid = 1; bus.wr1_addr = 6'd4; bus.wr1_data = 32'h0BAD_0004;
        bus.rd_valid  = 1; bus.rd_addr1 = 6'd3; bus.rd_addr2 = 6'd4;
        #1;
        for (int c = 0; c <= STARVE; c++) begin
            if (c > 0) tick();
            n_vec++; if (bus.rd_ready !== (c == STARVE)) begin n_err++; $display("FAIL starve_rd c=%0d got=%b exp=%b", c, bus.rd_ready, c == STARVE); end
            n_vec++; if ((bus.wr0_ready | bus.wr1_ready) !== (c == 0 || c == 2)) begin n_err++; $display("FAIL starve_wr c=%0d got=%b", c, bus.wr0_ready | bus.wr1_ready); end
            if (bus.wr0_ready) model_write(bus.wr0_addr, bus.wr0_data);
            if (bus.wr1_ready) model_write(bus.wr1_addr, bus.wr1_data);
            if (bus.rd_ready) begin e1 = shadow[3]; e2 = shadow[4]; end
        end
        tick();
        clear_inputs();
        n_vec++; if (bus.rd_done !== 1'b0) begin n_err++; $display("FAIL starve_early_done got=%b exp=0", bus.rd_done); end
        tick();
        n_vec++; if ({bus.rd_done, bus.rd_data1, bus.rd_data2} !== {1'b1, e1, e2}) begin n_err++; $display("FAIL starve_data got=%b %h %h exp=1 %h %h", bus.rd_done, bus.rd_data1, bus.rd_data2, e1, e2); end
        tick();
    endtask

    task automatic test_write_read();
        bus.wr0_valid = 1; bus.wr0_addr = 6'd5; bus.wr0_data = 32'hDEAD_BEEF;
        #1;
        n_vec++; if (bus.wr0_ready !== 1'b1) begin n_err++; $display("FAIL wrrd_accept got=%b exp=1", bus.wr0_ready); end
        model_write(6'd5, 32'hDEAD_BEEF);
        tick();
        bus.wr0_valid = 0;
        n_vec++; if ({bus.rf_write, bus.rf_address_wr, bus.rf_data_wr} !== {1'b1, 6'd5, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL wrrd_write got=%b %0d %h exp=1 5 deadbeef", bus.rf_write, bus.rf_address_wr, bus.rf_data_wr); end
        tick();
        n_vec++; if (bus.rf_write !== 1'b0) begin n_err++; $display("FAIL wrrd_gap got=%b exp=0", bus.rf_write); end
        bus.rd_valid = 1; bus.rd_addr1 = 6'd5; bus.rd_addr2 = 6'd0;
        #1;
        n_vec++; if (bus.rd_ready !== 1'b1) begin n_err++; $display("FAIL wrrd_rdacc got=%b exp=1", bus.rd_ready); end
        tick();
        bus.rd_valid = 0;
        n_vec++; if ({bus.rd_done, bus.rf_address1, bus.rf_address2} !== {1'b0, 6'd5, 6'd0}) begin n_err++; $display("FAIL wrrd_read got=%b %0d %0d exp=0 5 0", bus.rd_done, bus.rf_address1, bus.rf_address2); end
        tick();
        n_vec++; if ({bus.rd_done, bus.rd_data1, bus.rd_data2} !== {1'b1, 32'hDEAD_BEEF, shadow[0]}) begin n_err++; $display("FAIL wrrd_data got=%b %h %h exp=1 deadbeef %h", bus.rd_done, bus.rd_data1, bus.rd_data2, shadow[0]); end
        tick();
        n_vec++; if (bus.rd_done !== 1'b0) begin n_err++; $display("FAIL wrrd_pulse got=%b exp=0", bus.rd_done); end
    endtask

    task automatic test_discard();
        logic [DW-1:0] prior0;
        prior0 = shadow[0];
        bus.wr0_valid = 1; bus.wr0_addr = 6'd0; bus.wr0_data = 32'h0000_1234;
        #1;
        n_vec++; if (bus.wr0_ready !== 1'b1) begin n_err++; $display("FAIL disc_acc0 got=%b exp=1", bus.wr0_ready); end
        model_write(6'd0, 32'h0000_1234);
        tick();
        bus.wr0_valid = 0;
        bus.wr1_valid = 1; bus.wr1_addr = 6'd40; bus.wr1_data = 32'hFFFF_0040;
        #1;
        n_vec++; if ({bus.rf_write, bus.wr1_ready} !== 2'b00) begin n_err++; $display("FAIL disc_r0 got rfw/rdy=%b exp=00", {bus.rf_write, bus.wr1_ready}); end
        tick();
        n_vec++; if (bus.wr1_ready !== 1'b1) begin n_err++; $display("FAIL disc_acc40 got=%b exp=1", bus.wr1_ready); end
        model_write(6'd40, 32'hFFFF_0040);
        tick();
        bus.wr1_valid = 0;
        n_vec++; if (bus.rf_write !== 1'b0) begin n_err++; $display("FAIL disc_a40 rf_write got=%b exp=0", bus.rf_write); end
        tick();
        bus.rd_valid = 1; bus.rd_addr1 = 6'd0; bus.rd_addr2 = 6'd5;
        #1;
        n_vec++; if (bus.rd_ready !== 1'b1) begin n_err++; $display("FAIL disc_rdacc got=%b exp=1", bus.rd_ready); end
        tick();
        bus.rd_valid = 0;
        tick();
        n_vec++; if ({bus.rd_done, bus.rd_data1, bus.rd_data2} !== {1'b1, prior0, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL disc_read got=%b %h %h exp=1 %h deadbeef", bus.rd_done, bus.rd_data1, bus.rd_data2, prior0); end
        tick();
    endtask

    task automatic test_same_addr();
        bus.wr0_valid = 1; bus.wr0_addr = 6'd7; bus.wr0_data = 32'd1;
        #1;
        model_write(6'd7, 32'd1);
        tick();
        bus.wr0_valid = 0;
        bus.wr1_valid = 1; bus.wr1_addr = 6'd7; bus.wr1_data = 32'd2;
        tick();
        n_vec++; if (bus.wr1_ready !== 1'b1) begin n_err++; $display("FAIL same_acc got=%b exp=1", bus.wr1_ready); end
        model_write(6'd7, 32'd2);
        tick();
        bus.wr1_valid = 0;
        tick();
        bus.rd_valid = 1; bus.rd_addr1 = 6'd7; bus.rd_addr2 = 6'd7;
        tick();
        bus.rd_valid = 0;
        tick();
        n_vec++; if ({bus.rd_done, bus.rd_data1, bus.rd_data2} !== {1'b1, 32'd2, 32'd2}) begin n_err++; $display("FAIL same_read got=%b %h %h exp=1 2 2", bus.rd_done, bus.rd_data1, bus.rd_data2); end
        tick();
    endtask

    task automatic test_random(input int ncyc);
        logic          wk, prev_rfw, a0, a1, ar, rd1, rd2;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd, e1, e2;
        wk = 0; wa = '0; wd = '0; prev_rfw = 0; rd1 = 0; rd2 = 0; e1 = '0; e2 = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (!bus.wr0_valid && $urandom_range(0, 2) == 0) begin bus.wr0_valid = 1; bus.wr0_addr = rand_waddr(); bus.wr0_data = $urandom; end
            if (!bus.wr1_valid && $urandom_range(0, 2) == 0) begin bus.wr1_valid = 1; bus.wr1_addr = rand_waddr(); bus.wr1_data = $urandom; end
            if (!bus.rd_valid && $urandom_range(0, 3) == 0) begin bus.rd_valid = 1; bus.rd_addr1 = AW'($urandom_range(0, 31)); bus.rd_addr2 = AW'($urandom_range(0, 31)); end
            #1;
            a0 = bus.wr0_ready; a1 = bus.wr1_ready; ar = bus.rd_ready;
            n_vec++; if ((int'(a0) + int'(a1) + int'(ar) > 1) || (a0 && !bus.wr0_valid) || (a1 && !bus.wr1_valid) || (ar && !bus.rd_valid)) begin n_err++; $display("FAIL rnd_ready c=%0d got=%b%b%b", c, a0, a1, ar); end
            n_vec++; if (bus.rf_write !== wk) begin n_err++; $display("FAIL rnd_rfw c=%0d got=%b exp=%b", c, bus.rf_write, wk); end
            if (wk) begin n_vec++; if ({bus.rf_address_wr, bus.rf_data_wr} !== {wa, wd}) begin n_err++; $display("FAIL rnd_wrpay c=%0d got=%0d %h exp=%0d %h", c, bus.rf_address_wr, bus.rf_data_wr, wa, wd); end end
            n_vec++; if (bus.rf_write === 1'b1 && prev_rfw) begin n_err++; $display("FAIL rnd_gap c=%0d rf_write high two cycles, exp low between", c); end
            n_vec++; if (bus.rd_done !== rd2) begin n_err++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, bus.rd_done, rd2); end
            if (rd2) begin n_vec++; if ({bus.rd_data1, bus.rd_data2} !== {e1, e2}) begin n_err++; $display("FAIL rnd_rdata c=%0d got=%h %h exp=%h %h", c, bus.rd_data1, bus.rd_data2, e1, e2); end end
            prev_rfw = bus.rf_write;
            rd2 = rd1; rd1 = ar;
            wk = 0;
            if (a0) begin wk = kept(bus.wr0_addr); wa = bus.wr0_addr; wd = bus.wr0_data; model_write(wa, wd); end
            if (a1) begin wk = kept(bus.wr1_addr); wa = bus.wr1_addr; wd = bus.wr1_data; model_write(wa, wd); end
            if (ar) begin e1 = shadow[bus.rd_addr1[4:0]]; e2 = shadow[bus.rd_addr2[4:0]]; end
            tick();
            if (a0) bus.wr0_valid = 0;
            if (a1) bus.wr1_valid = 0;
            if (ar) bus.rd_valid = 0;
        end
        clear_inputs();
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_starvation();
        test_write_read();
        test_discard();
        test_same_addr();
        test_random(3000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
